nv_ram_rws_param: RTL and testbench
===================================

# nv_ram_rws_param

Parametrised two-port register-file RAM model: one write port, one read port, one clock. It generalises the fixed 64x256 read-write-separate RAM model with configurable depth and width and a per-byte write mask. Read data is captured in a register, with a valid flag and an optional second output stage, so read data stays stable after the read. It replaces the per-size rws RAM models in FPGA builds wherever CDMA/CBUF/SDP buffers need masked or pipelined reads.

## Interface
Parameters:
- DEPTH, 64: number of words; any value 2..4096, not required to be a power of two.
- WIDTH, 256: word width in bits; must be a multiple of 8.
- AW, 6: address width; must satisfy 2^AW >= DEPTH.
- OREG, 0: 0 = read latency 1; 1 = one extra output register, read latency 2.

Ports:
- clk, input, 1: single clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- ra, input, AW: read address.
- re, input, 1: read enable.
- dout, output, WIDTH: registered read data.
- dout_vld, output, 1: dout carries data from a read issued latency cycles earlier.
- wa, input, AW: write address.
- we, input, 1: write enable.
- wmask, input, WIDTH/8: byte write enables; bit i covers di[8i+7:8i].
- di, input, WIDTH: write data.
- pwrbus_ram_pd, input, 32: power-down bus; accepted and ignored, kept for port compatibility.

## Operation
- Write: on a clk edge with we=1 and wa<DEPTH, every byte i with wmask[i]=1 takes di byte i. Bytes with wmask[i]=0 keep their value. With we=1 and wmask=0, nothing changes.
- Out-of-range write (wa>=DEPTH): ignored, no array change.
- Read: on a clk edge with re=1, M[ra] is sampled into the stage-1 data register and stage-1 valid is set. With re=0, stage-1 valid clears and the data register holds its last value.
- Out-of-range read (ra>=DEPTH): stage-1 data loads all zeros; valid is set as normal.
- Unlike the legacy model, dout does not follow later writes to the read address. It changes only when a new read completes.
- OREG=1: stage 2 copies stage-1 data and valid every cycle. Stage-2 data loads only when stage-1 valid=1, otherwise it holds. dout and dout_vld come from stage 2.
- OREG=0: dout and dout_vld come from stage 1.
- Collision (re=1, we=1, ra==wa, in range, same edge): the result depends on the macro; see Configuration.
- Reset: clears the valid bits and both data registers. The array is not cleared; its contents are undefined until written.

## Timing
- Reset values: dout=0, dout_vld=0. When reset=1, the read pipeline ignores re; writes issued during reset are discarded.
- Read latency: re at edge N gives dout/dout_vld at edge N+1 (OREG=0) or N+2 (OREG=1).
- Throughput: one read and one write per cycle, with no stalls and no back-pressure.
- Write-to-read: a write at edge N is visible to a read issued at edge N+1.
- Reset asserted with reads in flight: all in-flight valids drop at the next edge, and no stale dout_vld follows deassertion.
- dout_vld is a single-cycle pulse per read. Back-to-back reads give a continuous dout_vld.

## Configuration
- NV_RAM_RWS_PARAM_WRITE_BYPASS_EN defined: on a collision, the read returns the merged word. Bytes with wmask=1 come from di; the other bytes come from the old contents.
- Macro undefined: on a collision, the read returns the old contents (read-before-write). The array is still updated at that edge.

## Test plan
- Reset then idle, DEPTH=64, WIDTH=256, OREG=0: after reset, dout=0 and dout_vld=0. With re=1, ra=5 at edge N, dout_vld=1 at N+1 and low at N+2.
- Masked write: write all-ones to addr 3, then write di=0 with wmask=0x0000_0001 to addr 3. Reading addr 3 returns ones except byte 0 = 0x00.
- Collision: preload addr 7 = 0xAA bytes; same edge re=1/ra=7 and we=1/wa=7/di=0x55 bytes/full mask. Macro defined: dout=0x55 bytes; undefined: dout=0xAA bytes; in both cases a read of addr 7 next cycle returns 0x55 bytes.
- Hold: read addr 2 (=X), then write addr 2 = Y with re=0. dout stays X until the next read, which returns Y.
- OREG=1, DEPTH=48: reads at edges 0, 1, 2 to addrs 0, 47, 50 give dout at edges 2, 3, 4 with dout_vld high for 3 cycles. Addr 50 returns 0, and a write to addr 50 changes no word.
- Reset mid-read: re=1 at edge N, reset=1 at edge N+1 (OREG=1). dout_vld stays 0 through and after the reset, and dout=0.

Source files
------------

// File: rtl/nv_ram_rws_param.sv
// Parametrised 1W/1R register-file RAM with byte write mask and registered read data.
// Define NV_RAM_RWS_PARAM_WRITE_BYPASS_EN to forward same-edge write data on a read/write collision.
module nv_ram_rws_param #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 256,
  parameter int AW    = 6,
  parameter int OREG  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [AW-1:0]      ra,
  input  logic               re,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_vld,
  input  logic [AW-1:0]      wa,
  input  logic               we,
  input  logic [WIDTH/8-1:0] wmask,
  input  logic [WIDTH-1:0]   di,
  input  logic [31:0]        pwrbus_ram_pd
);

  localparam int NB = WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_A = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             ra_ok;
  logic             wa_ok;
  logic [IW-1:0]    ra_idx;
  logic [IW-1:0]    wa_idx;
  logic [WIDTH-1:0] rd_word;

  logic             s1_vld;
  logic [WIDTH-1:0] s1_data;

  logic             unused_pwr;

  assign unused_pwr = ^pwrbus_ram_pd;

  // DEPTH need not be a power of two, so range is checked on the full address.
  assign ra_ok  = {1'b0, ra} < DEPTH_A;
  assign wa_ok  = {1'b0, wa} < DEPTH_A;
  assign ra_idx = ra[IW-1:0];
  assign wa_idx = wa[IW-1:0];

  always_ff @(posedge clk) begin
    if (!reset && we && wa_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (wmask[i]) begin
          mem[wa_idx][8*i +: 8] <= di[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (ra_ok) begin
      rd_word = mem[ra_idx];
    end
`ifdef NV_RAM_RWS_PARAM_WRITE_BYPASS_EN
    if (ra_ok && we && (wa == ra)) begin
      for (int i = 0; i < NB; i++) begin
        if (wmask[i]) begin
          rd_word[8*i +: 8] = di[8*i +: 8];
        end
      end
    end
`endif
  end

  // Data register only loads on a read so dout stays stable between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_vld <= re;
      if (re) begin
        s1_data <= rd_word;
      end
    end
  end

  generate
    if (OREG != 0) begin : g_oreg
      logic             s2_vld;
      logic [WIDTH-1:0] s2_data;

      always_ff @(posedge clk) begin
        if (reset) begin
          s2_vld  <= 1'b0;
          s2_data <= '0;
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) begin
            s2_data <= s1_data;
          end
        end
      end

      assign dout     = s2_data;
      assign dout_vld = s2_vld;
    end else begin : g_noreg
      assign dout     = s1_data;
      assign dout_vld = s1_vld;
    end
  endgenerate

endmodule

// File: tb/tb_nv_ram_rws_param.sv
// Randomised scoreboard bench for nv_ram_rws_param: one OREG=0 DEPTH=64 instance and one
// OREG=1 DEPTH=48 instance share stimulus; a word-array model predicts every read.
module tb_nv_ram_rws_param;

  localparam int W  = 256;
  localparam int NB = W / 8;
  localparam int AW = 6;
  localparam int DA = 64;
  localparam int DB = 48;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          re = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] ra = '0;
  logic [AW-1:0] wa = '0;
  logic [NB-1:0] wmask = '0;
  logic [W-1:0]  di = '0;
  logic [31:0]   pwr = '0;

  logic [W-1:0]  dout_a;
  logic [W-1:0]  dout_b;
  logic          vld_a;
  logic          vld_b;

  nv_ram_rws_param #(.DEPTH(DA), .WIDTH(W), .AW(AW), .OREG(0)) dut_a (
    .clk(clk), .reset(reset), .ra(ra), .re(re), .dout(dout_a), .dout_vld(vld_a),
    .wa(wa), .we(we), .wmask(wmask), .di(di), .pwrbus_ram_pd(pwr)
  );

  nv_ram_rws_param #(.DEPTH(DB), .WIDTH(W), .AW(AW), .OREG(1)) dut_b (
    .clk(clk), .reset(reset), .ra(ra), .re(re), .dout(dout_b), .dout_vld(vld_b),
    .wa(wa), .we(we), .wmask(wmask), .di(di), .pwrbus_ram_pd(pwr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t         qa[$];
  exp_t         qb[$];
  logic [W-1:0] ma [DA];
  logic [W-1:0] mb [DB];
  logic [W-1:0] hold_a = '0;
  logic [W-1:0] hold_b = '0;
  int           cyc = 0;
  logic         rst_seen = 1'b1;
  int           errors = 0;
  int           checks = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < W/32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] nw,
                                         input logic [NB-1:0] m);
    logic [W-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Drives one edge worth of inputs and updates the model to the state after that edge.
  task automatic applyStimulus(input logic rst, input logic r, input int raddr, input logic w,
                               input int waddr, input logic [NB-1:0] m, input logic [W-1:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; re = r; ra = AW'(raddr); we = w; wa = AW'(waddr); wmask = m; di = d;
    if (rst) begin
      while (qa.size() > 0 && qa[$].due >= cyc + 1) void'(qa.pop_back());
      while (qb.size() > 0 && qb[$].due >= cyc + 1) void'(qb.pop_back());
    end else begin
      if (r) begin
        e.due  = cyc + 1;
        e.data = (raddr < DA) ? ma[raddr] : '0;
`ifdef NV_RAM_RWS_PARAM_WRITE_BYPASS_EN
        if (w && waddr == raddr && raddr < DA) e.data = merge(e.data, d, m);
`endif
        qa.push_back(e);
        e.due  = cyc + 2;
        e.data = (raddr < DB) ? mb[raddr] : '0;
`ifdef NV_RAM_RWS_PARAM_WRITE_BYPASS_EN
        if (w && waddr == raddr && raddr < DB) e.data = merge(e.data, d, m);
`endif
        qb.push_back(e);
      end
      if (w) begin
        if (waddr < DA) ma[waddr] = merge(ma[waddr], d, m);
        if (waddr < DB) mb[waddr] = merge(mb[waddr], d, m);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, '0, '0);
  endtask

  // Monitor: outputs of the edge just past are compared mid-cycle against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      checkOutput("rst_vld_a", W'(vld_a), '0);
      checkOutput("rst_dout_a", dout_a, '0);
      checkOutput("rst_vld_b", W'(vld_b), '0);
      checkOutput("rst_dout_b", dout_b, '0);
      hold_a = '0;
      hold_b = '0;
    end else begin
      if (qa.size() > 0 && qa[0].due == cyc) begin
        e = qa.pop_front();
        checkOutput("vld_a", W'(vld_a), W'(1));
        checkOutput("dout_a", dout_a, e.data);
        hold_a = e.data;
      end else begin
        checkOutput("idle_vld_a", W'(vld_a), '0);
        checkOutput("hold_a", dout_a, hold_a);
      end
      if (qb.size() > 0 && qb[0].due == cyc) begin
        e = qb.pop_front();
        checkOutput("vld_b", W'(vld_b), W'(1));
        checkOutput("dout_b", dout_b, e.data);
        hold_b = e.data;
      end else begin
        checkOutput("idle_vld_b", W'(vld_b), '0);
        checkOutput("hold_b", dout_b, hold_b);
      end
    end
  end

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] aa;
    logic [W-1:0] h55;
    int           rad;
    int           wad;
    logic [NB-1:0] m;
    ones = '1;
    aa   = {NB{8'hAA}};
    h55  = {NB{8'h55}};

    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'($urandom), $urandom_range(63), 1'b0, 0, '0, '0);
    idle(1);
    for (int a = 0; a < DA; a++) applyStimulus(1'b0, 1'b0, 0, 1'b1, a, '1, rand_word());

    applyStimulus(1'b0, 1'b1, 5, 1'b0, 0, '0, '0);
    idle(2);

    applyStimulus(1'b0, 1'b0, 0, 1'b1, 3, '1, ones);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 3, NB'(1), '0);
    applyStimulus(1'b0, 1'b1, 3, 1'b0, 0, '0, '0);
    idle(2);

    applyStimulus(1'b0, 1'b0, 0, 1'b1, 7, '1, aa);
    applyStimulus(1'b0, 1'b1, 7, 1'b1, 7, '1, h55);
    applyStimulus(1'b0, 1'b1, 7, 1'b0, 0, '0, '0);
    idle(2);

    applyStimulus(1'b0, 1'b1, 2, 1'b0, 0, '0, '0);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 2, '1, rand_word());
    idle(3);
    applyStimulus(1'b0, 1'b1, 2, 1'b0, 0, '0, '0);
    idle(3);

    applyStimulus(1'b0, 1'b1, 0, 1'b0, 0, '0, '0);
    applyStimulus(1'b0, 1'b1, 47, 1'b0, 0, '0, '0);
    applyStimulus(1'b0, 1'b1, 50, 1'b0, 0, '0, '0);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 50, '1, rand_word());
    applyStimulus(1'b0, 1'b1, 50, 1'b0, 0, '0, '0);
    applyStimulus(1'b0, 1'b1, 2, 1'b0, 0, '0, '0);
    idle(3);

    applyStimulus(1'b0, 1'b1, 4, 1'b0, 0, '0, '0);
    applyStimulus(1'b1, 1'b1, 4, 1'b1, 9, '1, rand_word());
    idle(3);
    applyStimulus(1'b0, 1'b1, 9, 1'b0, 0, '0, '0);
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      rad = $urandom_range(63);
      wad = ($urandom_range(4) == 0) ? rad : $urandom_range(63);
      case ($urandom_range(3))
        0:       m = '1;
        1:       m = '0;
        default: m = NB'($urandom);
      endcase
      applyStimulus(1'($urandom_range(99) == 0), 1'($urandom), rad, 1'($urandom), wad, m,
                    rand_word());
    end

    idle(4);
    @(negedge clk);
    #1;
    checkOutput("drain_qa", W'(qa.size()), '0);
    checkOutput("drain_qb", W'(qb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
